// File: rtl/comparator_stim_gen_pkg.sv
// comparator_stim_gen_pkg: shared state encoding, vector table and the golden comparator function.
package comparator_pkg;

    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

    localparam logic [1:0] VEC_TABLE [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    function automatic logic cmp_expect(input logic a, input logic b);
        return ~(a ^ b);
    endfunction

endpackage

// File: rtl/comparator_stim_gen_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4) with seed load and step enable.
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [7:0] seed_i,
    output logic [7:0] q_o
);

    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = load_i ? seed_i
               : en_i   ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
               :          lfsr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= seed_i;
        else     lfsr_q <= lfsr_d;
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/comparator_stim_gen.sv
// comparator_stim_gen: clocked stimulus/check engine for a 1-bit equality comparator.
// Define COMP_STIM_RANDOM_EN to source operands from an LFSR instead of the fixed 00,01,10,11 sweep.
module comparator_stim_gen
    import comparator_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 20,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 8,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             input1,
    output logic             input2,
    input  logic             cmp_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       last_fail
);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      pcnt_q, pcnt_d;
    logic [31:0]      scnt_q, scnt_d;
    logic [1:0]       ops_q, ops_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       lf_q, lf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             mismatch;
    logic [1:0]       vec;

    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign mismatch = cmp_out != cmp_expect(ops_q[1], ops_q[0]);

`ifdef COMP_STIM_RANDOM_EN
    logic [7:0] lfsr;

    lfsr8 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .en_i   (state_q == DRIVE),
        .seed_i (LFSR_SEED),
        .q_o    (lfsr)
    );

    assign vec = lfsr[1:0];
`else
    assign vec = VEC_TABLE[idx_q];
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        scnt_d  = scnt_q;
        ops_d   = ops_q;
        err_d   = err_q;
        lf_d    = lf_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = DRIVE;
                    idx_d   = 2'd0;
                    pcnt_d  = 32'd0;
                    err_d   = '0;
                    lf_d    = 2'b00;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            DRIVE: begin
                ops_d   = vec;
                scnt_d  = 32'd0;
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = (scnt_q == SETTLE_CYCLES - 1) ? CHECK : SETTLE;
                scnt_d  = (scnt_q == SETTLE_CYCLES - 1) ? scnt_q : scnt_q + 32'd1;
            end
            CHECK: begin
                // last_fail tracks every mismatch, even once the counter is pinned at all-ones
                if (mismatch) begin
                    err_d = &err_q ? err_q : err_q + 1'b1;
                    lf_d  = ops_q;
                end
                if (idx_q == 2'd3 && pcnt_q == PASSES - 1) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 2'd1;
                    pcnt_d  = (idx_q == 2'd3) ? pcnt_q + 32'd1 : pcnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            pcnt_q  <= 32'd0;
            scnt_q  <= 32'd0;
            ops_q   <= 2'b00;
            err_q   <= '0;
            lf_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
            ops_q   <= ops_d;
            err_q   <= err_d;
            lf_q    <= lf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign input1    = ops_q[1];
    assign input2    = ops_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = done_q && (err_q == '0);
    assign err_count = err_q;
    assign last_fail = lf_q;

endmodule
